// File: rtl/serial_rca.sv
// Digit-serial ripple-carry adder: WIDTH-bit add, DIGIT bits per clock, LSB digit first.
// Optional subtract mode (a - b - c_in) when RCA_SUB_EN is defined.
module serial_rca #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned N     = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("serial_rca: illegal WIDTH/DIGIT combination");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   b_eff_c;
    logic               cin_eff_c;
    logic [DIGIT-1:0]   dsum_c;
    logic               ripple_c;
    logic               msb_cin_c;

    // Subtract is folded into operand capture: a + ~b + ~c_in.
`ifdef RCA_SUB_EN
    assign b_eff_c   = sub ? ~b : b;
    assign cin_eff_c = c_in ^ sub;
`else
    logic sub_unused;
    assign sub_unused = sub;
    assign b_eff_c    = b;
    assign cin_eff_c  = c_in;
`endif

    // One DIGIT-wide chain of full adders on the low slice of the operand shifters.
    always_comb begin
        ripple_c  = carry_q;
        msb_cin_c = carry_q;
        dsum_c    = '0;
        for (int i = 0; i < int'(DIGIT); i++) begin
            msb_cin_c = ripple_c;
            dsum_c[i] = a_q[i] ^ b_q[i] ^ ripple_c;
            ripple_c  = (a_q[i] & b_q[i]) | (ripple_c & (a_q[i] ^ b_q[i]));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        s_d     = s_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_eff_c;
                    carry_d = cin_eff_c;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = ripple_c;
                acc_d   = (acc_q >> DIGIT) | (WIDTH'(dsum_c) << (WIDTH - DIGIT));
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    s_d     = acc_d;
                    c_out_d = ripple_c;
                    ovf_d   = msb_cin_c ^ ripple_c;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign s     = s_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_rca.sv
// Directed bench for serial_rca: three instances (DIGIT = 1, 4, 2) on a shared clock/reset.
module tb_serial_rca;

    logic       clk;
    logic       rst;
    logic [2:0] start_v;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       sub;
    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] c_out_v;
    logic [2:0] ovf_v;
    logic [7:0] s_v [3];

    int n_cmp;
    int n_bad;

    serial_rca #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b), .c_in(c_in), .sub(sub),
        .busy(busy_v[0]), .done(done_v[0]), .s(s_v[0]), .c_out(c_out_v[0]), .ovf(ovf_v[0])
    );

    serial_rca #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a), .b(b), .c_in(c_in), .sub(sub),
        .busy(busy_v[1]), .done(done_v[1]), .s(s_v[1]), .c_out(c_out_v[1]), .ovf(ovf_v[1])
    );

    serial_rca #(.WIDTH(8), .DIGIT(2)) u_d2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a), .b(b), .c_in(c_in), .sub(sub),
        .busy(busy_v[2]), .done(done_v[2]), .s(s_v[2]), .c_out(c_out_v[2]), .ovf(ovf_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; launches one op, waits (bounded) for done, checks timing and result.
    // glitch=1 pulses start with different operands on the third RUN cycle.
    task automatic do_op(input int sel, input int n,
                         input logic [7:0] av, input logic [7:0] bv, input logic cv, input logic sv,
                         input logic [7:0] es, input logic ec, input logic eo,
                         input string tag, input bit glitch);
        int edges;
        int busy_cnt;
        a = av; b = bv; c_in = cv; sub = sv;
        start_v[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[sel] = 1'b0;
        edges    = 0;
        busy_cnt = 0;
        while (done_v[sel] !== 1'b1 && edges < 40) begin
            if (busy_v[sel] === 1'b1) busy_cnt++;
            if (glitch && edges == 2) begin
                start_v[sel] = 1'b1;
                a = ~av; b = 8'h55; c_in = ~cv;
            end else begin
                start_v[sel] = 1'b0;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start_v[sel] = 1'b0;
        check({tag, "_lat"},   32'(edges), 32'(n));
        check({tag, "_busy"},  32'(busy_cnt), 32'(n));
        check({tag, "_bsy0"},  32'(busy_v[sel]), 32'(1'b0));
        check({tag, "_s"},     32'(s_v[sel]), 32'(es));
        check({tag, "_cout"},  32'(c_out_v[sel]), 32'(ec));
        check({tag, "_ovf"},   32'(ovf_v[sel]), 32'(eo));
    endtask

    initial begin
        int dones;
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        start_v = 3'b000;
        a = 8'h00; b = 8'h00; c_in = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_busy", 32'(busy_v[k]), 32'(1'b0));
            check("rst_done", 32'(done_v[k]), 32'(1'b0));
            check("rst_s",    32'(s_v[k]), 32'(8'h00));
            check("rst_cout", 32'(c_out_v[k]), 32'(1'b0));
            check("rst_ovf",  32'(ovf_v[k]), 32'(1'b0));
        end

        // rst and start on the same edge: reset wins
        a = 8'h11; b = 8'h22; start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_start_busy", 32'(busy_v[0]), 32'(1'b0));
        start_v[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        do_op(0, 8, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "ff_01", 1'b0);
        @(negedge clk);
        check("idle_after_done", 32'(done_v[0]), 32'(1'b0));
        check("hold_s_idle",     32'(s_v[0]), 32'(8'h00));
        do_op(0, 8, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "7f_01", 1'b0);
        @(negedge clk);
        do_op(0, 8, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "80_80", 1'b0);
        @(negedge clk);

        do_op(1, 2, 8'h3C, 8'h45, 1'b1, 1'b0, 8'h82, 1'b0, 1'b1, "d4_3c_45", 1'b0);
        @(negedge clk);

`ifdef RCA_SUB_EN
        do_op(2, 4, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "d2_sub", 1'b0);
`else
        do_op(2, 4, 8'h05, 8'h07, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b0, "d2_sub", 1'b0);
`endif
        @(negedge clk);

        // start mid-RUN is ignored
        do_op(0, 8, 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, "glitch", 1'b1);
        @(negedge clk);

        // back-to-back: second start issued in the DONE cycle
        do_op(1, 2, 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, "b2b_1", 1'b0);
        do_op(1, 2, 8'hF0, 8'h20, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, "b2b_2", 1'b0);
        @(negedge clk);

        // reset abort on the third RUN cycle
        a = 8'h0F; b = 8'h01; c_in = 1'b0; sub = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy_pre", 32'(busy_v[0]), 32'(1'b1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy_v[0]), 32'(1'b0));
        check("abort_done", 32'(done_v[0]), 32'(1'b0));
        check("abort_s",    32'(s_v[1]), 32'(8'h00));
        check("abort_s0",   32'(s_v[0]), 32'(8'h00));
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) dones++;
        end
        check("abort_no_done", 32'(dones), 32'(0));
        do_op(0, 8, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, "post_abort", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
